// File: rtl/spi_master_ctrl.sv
// SPI master command engine: serializes one {cmd_type, cmd_data} command per
// 11-bit frame onto MOSI/ss_n and captures the read-data byte returned on MISO.
module spi_master_ctrl #(
    parameter int unsigned MISO_LAT = 2,
    parameter int unsigned IDLE_GAP = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       MOSI,
    output logic       ss_n,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE, START, SEL, SHIFT, WAIT, RECV, STOP, GAP
    } state_t;

    localparam int unsigned WAIT_CYC = (MISO_LAT > 1) ? MISO_LAT - 2 : 0;
    localparam int unsigned GAP_CYC  = (IDLE_GAP > 1) ? IDLE_GAP - 2 : 0;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYC);
    localparam logic [3:0]  GAP_LOAD  = 4'(GAP_CYC);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic [9:0] din_q, din_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       busy_q, busy_d;
    logic       mosi_q, mosi_d;
    logic       ss_n_q, ss_n_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        din_d      = din_q;
        shreg_d    = shreg_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = START;
                    din_d   = {cmd_type, cmd_data};
                end
            end
            START: state_d = SEL;
            SEL: begin
                state_d = SHIFT;
                cnt_d   = 4'd9;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    if (din_q[9:8] == 2'b11) begin
                        if (MISO_LAT == 1) begin
                            state_d = RECV;
                            cnt_d   = 4'd7;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RECV;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECV: begin
                shreg_d = {shreg_q[6:0], MISO};
                if (cnt_q == '0) begin
                    // last sample goes straight into rd_data so it is valid in STOP
                    state_d    = STOP;
                    rd_data_d  = shreg_d;
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STOP: begin
                if (IDLE_GAP == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        ss_n_d = !(state_d inside {START, SEL, SHIFT, WAIT, RECV});
        mosi_d = 1'b0;
        if (state_d == SEL) begin
            mosi_d = din_d[9];
        end else if (state_d == SHIFT) begin
            mosi_d = din_d[cnt_d];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            din_q      <= '0;
            shreg_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            din_q      <= din_d;
            shreg_q    <= shreg_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign MOSI      = mosi_q;
    assign ss_n      = ss_n_q;

endmodule
